// File: rtl/lcd_pkg.sv
// Shared constants for the LCD clock formatter: ASCII codes, screen positions
// and the set_mode field encodings.
package lcd_pkg;

   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_COLON = 8'h3A;
   localparam logic [7:0] ASCII_QMARK = 8'h3F;
   localparam logic [7:0] ASCII_ZERO  = 8'h30;

   // Character positions of the variable fields; line 2 starts at 16.
   localparam logic [4:0] POS_HOUR_T   = 5'd6;
   localparam logic [4:0] POS_HOUR_O   = 5'd7;
   localparam logic [4:0] POS_COLON_HM = 5'd8;
   localparam logic [4:0] POS_MIN_T    = 5'd9;
   localparam logic [4:0] POS_MIN_O    = 5'd10;
   localparam logic [4:0] POS_COLON_MS = 5'd11;
   localparam logic [4:0] POS_SEC_T    = 5'd12;
   localparam logic [4:0] POS_SEC_O    = 5'd13;
   localparam logic [4:0] POS_AHOUR_T  = 5'd22;
   localparam logic [4:0] POS_AHOUR_O  = 5'd23;
   localparam logic [4:0] POS_COLON_AL = 5'd24;
   localparam logic [4:0] POS_AMIN_T   = 5'd25;
   localparam logic [4:0] POS_AMIN_O   = 5'd26;
   localparam logic [4:0] POS_ONOFF    = 5'd28;
   localparam logic [4:0] POS_LAST     = 5'd31;

   typedef enum logic [2:0] {
      MODE_NONE  = 3'd0,
      MODE_HOUR  = 3'd1,
      MODE_MIN   = 3'd2,
      MODE_SEC   = 3'd3,
      MODE_AHOUR = 3'd4,
      MODE_AMIN  = 3'd5
   } set_mode_e;

   function automatic logic [7:0] bcd_to_ascii(input logic [3:0] nibble);
      if (nibble > 4'd9) begin
         return ASCII_QMARK;
      end
      return ASCII_ZERO + {4'h0, nibble};
   endfunction

endpackage

// File: rtl/lcd_tick_gen.sv
// Free-running divider producing a one-cycle en_clk strobe every EN_DIV clocks.
module lcd_tick_gen
   import lcd_pkg::*;
#(
   parameter int unsigned EN_DIV = 50000
) (
   input  logic clk,
   input  logic rst,
   output logic en_clk
);

   localparam int unsigned CW = (EN_DIV > 1) ? $clog2(EN_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(EN_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CNT_MAX) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Strobe decoded straight from the counter flop, so it is low in reset.
   assign en_clk = (cnt_q == CNT_MAX);

endmodule

// File: rtl/lcd_clock_formatter.sv
// Turns a snapshotted time/alarm into the 32 ASCII characters of a 2x16 LCD,
// blinking the field being edited and pacing the LCD driver with en_clk.
module lcd_clock_formatter
   import lcd_pkg::*;
#(
   parameter int unsigned EN_DIV       = 50000,
   parameter int unsigned BLINK_FRAMES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] index_char,
   input  logic [7:0] hour_bcd,
   input  logic [7:0] min_bcd,
   input  logic [7:0] sec_bcd,
   input  logic [7:0] alarm_hour_bcd,
   input  logic [7:0] alarm_min_bcd,
   input  logic       alarm_on,
   input  logic [2:0] set_mode,
   output logic       en_clk,
   output logic [7:0] data_char
);

   localparam logic [7:0] FRAME_LAST = 8'(BLINK_FRAMES - 1);

   logic [4:0] prev_idx_q,  prev_idx_d;
   logic       first_q,     first_d;
   logic [7:0] snap_hour_q, snap_hour_d;
   logic [7:0] snap_min_q,  snap_min_d;
   logic [7:0] snap_sec_q,  snap_sec_d;
   logic [7:0] snap_ah_q,   snap_ah_d;
   logic [7:0] snap_am_q,   snap_am_d;
   logic       snap_on_q,   snap_on_d;
   logic [2:0] mode_q,      mode_d;
   logic [7:0] frame_cnt_q, frame_cnt_d;
   logic       blink_q,     blink_d;
   logic [7:0] data_char_q, data_char_d;

   logic frame_wrap;
   logic snap_load;
   logic mode_change;

   lcd_tick_gen #(
      .EN_DIV (EN_DIV)
   ) u_tick (
      .clk    (clk),
      .rst    (rst),
      .en_clk (en_clk)
   );

   // A frame boundary is the driver stepping from the last position back to 0;
   // the snapshot only moves there so a frame never mixes two input values.
   always_comb begin
      prev_idx_d  = index_char;
      frame_wrap  = (prev_idx_q == POS_LAST) && (index_char == 5'd0);
      snap_load   = frame_wrap || first_q;
      first_d     = 1'b0;
      snap_hour_d = snap_hour_q;
      snap_min_d  = snap_min_q;
      snap_sec_d  = snap_sec_q;
      snap_ah_d   = snap_ah_q;
      snap_am_d   = snap_am_q;
      snap_on_d   = snap_on_q;
      if (snap_load) begin
         snap_hour_d = hour_bcd;
         snap_min_d  = min_bcd;
         snap_sec_d  = sec_bcd;
         snap_ah_d   = alarm_hour_bcd;
         snap_am_d   = alarm_min_bcd;
         snap_on_d   = alarm_on;
      end
   end

   // Changing the edited field restarts the blink visible, overriding any
   // toggle that would happen on the same frame boundary.
   always_comb begin
      mode_d      = set_mode;
      mode_change = (set_mode != mode_q);
      frame_cnt_d = frame_cnt_q;
      blink_d     = blink_q;
      if (mode_change) begin
         frame_cnt_d = 8'd0;
         blink_d     = 1'b0;
      end else if (frame_wrap) begin
         if (frame_cnt_q == FRAME_LAST) begin
            frame_cnt_d = 8'd0;
            blink_d     = ~blink_q;
         end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
         end
      end
   end

   logic [7:0] hour_t, hour_o, min_t, min_o, sec_t, sec_o;
   logic [7:0] ah_t, ah_o, am_t, am_o;
   logic       blank_hour, blank_min, blank_sec, blank_ah, blank_am;

   always_comb begin
      blank_hour = blink_q && (mode_q == MODE_HOUR);
      blank_min  = blink_q && (mode_q == MODE_MIN);
      blank_sec  = blink_q && (mode_q == MODE_SEC);
      blank_ah   = blink_q && (mode_q == MODE_AHOUR);
      blank_am   = blink_q && (mode_q == MODE_AMIN);
      hour_t = blank_hour ? ASCII_SPACE : bcd_to_ascii(snap_hour_q[7:4]);
      hour_o = blank_hour ? ASCII_SPACE : bcd_to_ascii(snap_hour_q[3:0]);
      min_t  = blank_min  ? ASCII_SPACE : bcd_to_ascii(snap_min_q[7:4]);
      min_o  = blank_min  ? ASCII_SPACE : bcd_to_ascii(snap_min_q[3:0]);
      sec_t  = blank_sec  ? ASCII_SPACE : bcd_to_ascii(snap_sec_q[7:4]);
      sec_o  = blank_sec  ? ASCII_SPACE : bcd_to_ascii(snap_sec_q[3:0]);
      ah_t   = blank_ah   ? ASCII_SPACE : bcd_to_ascii(snap_ah_q[7:4]);
      ah_o   = blank_ah   ? ASCII_SPACE : bcd_to_ascii(snap_ah_q[3:0]);
      am_t   = blank_am   ? ASCII_SPACE : bcd_to_ascii(snap_am_q[7:4]);
      am_o   = blank_am   ? ASCII_SPACE : bcd_to_ascii(snap_am_q[3:0]);
   end

   // Screen layout: "TIME  HH:MM:SS  " then "ALARM HH:MM ON  " / "ALARM HH:MM OFF ".
   always_comb begin
      data_char_d = ASCII_SPACE;
      case (index_char)
         5'd0:         data_char_d = "T";
         5'd1:         data_char_d = "I";
         5'd2:         data_char_d = "M";
         5'd3:         data_char_d = "E";
         5'd4:         data_char_d = ASCII_SPACE;
         5'd5:         data_char_d = ASCII_SPACE;
         POS_HOUR_T:   data_char_d = hour_t;
         POS_HOUR_O:   data_char_d = hour_o;
         POS_COLON_HM: data_char_d = ASCII_COLON;
         POS_MIN_T:    data_char_d = min_t;
         POS_MIN_O:    data_char_d = min_o;
         POS_COLON_MS: data_char_d = ASCII_COLON;
         POS_SEC_T:    data_char_d = sec_t;
         POS_SEC_O:    data_char_d = sec_o;
         5'd14:        data_char_d = ASCII_SPACE;
         5'd15:        data_char_d = ASCII_SPACE;
         5'd16:        data_char_d = "A";
         5'd17:        data_char_d = "L";
         5'd18:        data_char_d = "A";
         5'd19:        data_char_d = "R";
         5'd20:        data_char_d = "M";
         5'd21:        data_char_d = ASCII_SPACE;
         POS_AHOUR_T:  data_char_d = ah_t;
         POS_AHOUR_O:  data_char_d = ah_o;
         POS_COLON_AL: data_char_d = ASCII_COLON;
         POS_AMIN_T:   data_char_d = am_t;
         POS_AMIN_O:   data_char_d = am_o;
         5'd27:        data_char_d = ASCII_SPACE;
         POS_ONOFF:    data_char_d = "O";
         5'd29:        data_char_d = snap_on_q ? "N" : "F";
         5'd30:        data_char_d = snap_on_q ? ASCII_SPACE : "F";
         5'd31:        data_char_d = ASCII_SPACE;
         default:      data_char_d = ASCII_SPACE;
      endcase
   end

   // first_q resets high so the snapshot also loads on the first clock out of reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_idx_q  <= 5'd0;
         first_q     <= 1'b1;
         snap_hour_q <= 8'h00;
         snap_min_q  <= 8'h00;
         snap_sec_q  <= 8'h00;
         snap_ah_q   <= 8'h00;
         snap_am_q   <= 8'h00;
         snap_on_q   <= 1'b0;
         mode_q      <= 3'd0;
         frame_cnt_q <= 8'd0;
         blink_q     <= 1'b0;
         data_char_q <= ASCII_SPACE;
      end else begin
         prev_idx_q  <= prev_idx_d;
         first_q     <= first_d;
         snap_hour_q <= snap_hour_d;
         snap_min_q  <= snap_min_d;
         snap_sec_q  <= snap_sec_d;
         snap_ah_q   <= snap_ah_d;
         snap_am_q   <= snap_am_d;
         snap_on_q   <= snap_on_d;
         mode_q      <= mode_d;
         frame_cnt_q <= frame_cnt_d;
         blink_q     <= blink_d;
         data_char_q <= data_char_d;
      end
   end

   assign data_char = data_char_q;

endmodule

// File: tb/tb_lcd_clock_formatter.sv
// Directed bench for lcd_clock_formatter with a short divider and blink period,
// comparing the LCD character stream against hand-written screen contents.
module tb_lcd_clock_formatter;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] index_char;
   logic [7:0] hour_bcd, min_bcd, sec_bcd, alarm_hour_bcd, alarm_min_bcd;
   logic       alarm_on;
   logic [2:0] set_mode;
   logic       en_clk;
   logic [7:0] data_char;

   int checkCount = 0;
   int failCount  = 0;
   logic [7:0] frameBuf [0:31];

   always #5 clk = ~clk;

   lcd_clock_formatter #(
      .EN_DIV       (4),
      .BLINK_FRAMES (2)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .index_char     (index_char),
      .hour_bcd       (hour_bcd),
      .min_bcd        (min_bcd),
      .sec_bcd        (sec_bcd),
      .alarm_hour_bcd (alarm_hour_bcd),
      .alarm_min_bcd  (alarm_min_bcd),
      .alarm_on       (alarm_on),
      .set_mode       (set_mode),
      .en_clk         (en_clk),
      .data_char      (data_char)
   );

   task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s actual=%02h expected=%02h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                                input logic [7:0] ah, input logic [7:0] am, input logic on);
      hour_bcd       = h;
      min_bcd        = m;
      sec_bcd        = s;
      alarm_hour_bcd = ah;
      alarm_min_bcd  = am;
      alarm_on       = on;
   endtask

   // Drive positions 0..31 one per clock; each byte is read one clock later.
   task automatic sweepFrame();
      for (int i = 0; i < 32; i++) begin
         index_char = 5'(i);
         @(negedge clk);
         frameBuf[i] = data_char;
      end
   endtask

   task automatic checkLine(input string tag, input int base, input string exp);
      for (int i = 0; i < 16; i++) begin
         checkOutput($sformatf("%s_pos%0d", tag, base + i), frameBuf[base + i], exp[i]);
      end
   endtask

   initial begin
      rst        = 1'b0;
      index_char = 5'd0;
      set_mode   = 3'd0;
      applyStimulus(8'h12, 8'h34, 8'h56, 8'h07, 8'h30, 1'b1);
      repeat (3) @(negedge clk);
      checkOutput("reset_en_clk", {7'b0, en_clk}, 8'h00);
      checkOutput("reset_data_char", data_char, 8'h20);

      rst = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         checkOutput($sformatf("en_clk_cycle%0d", k), {7'b0, en_clk}, 8'((k % 4) == 0));
         @(negedge clk);
      end

      sweepFrame();
      checkLine("line1", 0, "TIME  12:34:56  ");
      checkLine("line2", 16, "ALARM 07:30 ON  ");

      for (int i = 0; i < 20; i++) begin
         index_char = 5'(i);
         @(negedge clk);
      end
      sec_bcd = 8'h57;
      for (int i = 20; i < 32; i++) begin
         index_char = 5'(i);
         @(negedge clk);
      end
      index_char = 5'd12;
      @(negedge clk);
      checkOutput("sec_hold_tens", data_char, "5");
      index_char = 5'd13;
      @(negedge clk);
      checkOutput("sec_hold_ones", data_char, "6");
      index_char = 5'd31;
      @(negedge clk);
      sweepFrame();
      checkOutput("sec_new_tens", frameBuf[12], "5");
      checkOutput("sec_new_ones", frameBuf[13], "7");

      applyStimulus(8'h1A, 8'h34, 8'h57, 8'h07, 8'h30, 1'b0);
      sweepFrame();
      checkOutput("bad_bcd_tens", frameBuf[6], "1");
      checkOutput("bad_bcd_ones", frameBuf[7], "?");
      checkOutput("off_pos28", frameBuf[28], "O");
      checkOutput("off_pos29", frameBuf[29], "F");
      checkOutput("off_pos30", frameBuf[30], "F");
      checkOutput("off_pos31", frameBuf[31], " ");

      applyStimulus(8'h12, 8'h34, 8'h57, 8'h07, 8'h30, 1'b1);
      for (int f = 1; f <= 4; f++) begin
         if (f == 1) set_mode = 3'd1;
         sweepFrame();
         checkOutput($sformatf("blink_f%0d_pos6", f), frameBuf[6], (f <= 2) ? "1" : " ");
         checkOutput($sformatf("blink_f%0d_pos7", f), frameBuf[7], (f <= 2) ? "2" : " ");
         checkOutput($sformatf("blink_f%0d_pos8", f), frameBuf[8], ":");
         checkOutput($sformatf("blink_f%0d_pos9", f), frameBuf[9], "3");
      end
      checkOutput("blink_on_pos29", frameBuf[29], "N");
      set_mode = 3'd0;
      sweepFrame();
      checkOutput("unblink_pos6", frameBuf[6], "1");
      checkOutput("unblink_pos7", frameBuf[7], "2");

      for (int i = 0; i < 10; i++) begin
         index_char = 5'(i);
         @(negedge clk);
      end
      #2 rst = 1'b0;
      #1;
      checkOutput("midreset_data_char", data_char, 8'h20);
      checkOutput("midreset_en_clk", {7'b0, en_clk}, 8'h00);
      @(negedge clk);
      checkOutput("midreset_hold_data_char", data_char, 8'h20);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("post_reset_zero_snapshot", data_char, "0");
      @(negedge clk);
      checkOutput("post_reset_loaded", data_char, "3");
      checkOutput("post_reset_en_clk_low", {7'b0, en_clk}, 8'h00);
      @(negedge clk);
      checkOutput("post_reset_en_clk_first", {7'b0, en_clk}, 8'h01);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
